// File: rtl/crc_row_engine.sv
// Bit-serial CRC-16 engine: accepts up to eight 16-bit words after START and
// keeps one CRC result per word in SUM1..SUM8 until the next START or reset.
module crc_row_engine #(
    parameter int                    DATA_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0] POLY       = 16'h1021,
    parameter logic [DATA_WIDTH-1:0] INIT       = 16'h0000
) (
    input  logic                  HCLK,
    input  logic                  RESET,
    input  logic                  START,
    input  logic [1:0]            DLEN,
    input  logic [DATA_WIDTH-1:0] DATA_IN,
    input  logic                  DATA_VALID,
    output logic                  DATA_READY,
    output logic [DATA_WIDTH-1:0] SUM1,
    output logic [DATA_WIDTH-1:0] SUM2,
    output logic [DATA_WIDTH-1:0] SUM3,
    output logic [DATA_WIDTH-1:0] SUM4,
    output logic [DATA_WIDTH-1:0] SUM5,
    output logic [DATA_WIDTH-1:0] SUM6,
    output logic [DATA_WIDTH-1:0] SUM7,
    output logic [DATA_WIDTH-1:0] SUM8,
    output logic                  SUM_READY,
    output logic                  BUSY,
    output logic [3:0]            WORD_CNT
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_WORD = 2'd1;
    localparam logic [1:0] SHIFT     = 2'd2;
    localparam logic [1:0] DONE      = 2'd3;

    logic [1:0]            state;
    logic [DATA_WIDTH-1:0] crc_reg;
    logic [DATA_WIDTH-1:0] dat_reg;
    logic [3:0]            bit_cnt;
    logic [3:0]            len_q;
    logic [3:0]            word_cnt;
    logic                  sum_ready;
    logic [DATA_WIDTH-1:0] sum_q [8];

    logic                  fb;
    logic [DATA_WIDTH-1:0] crc_next;
    logic [3:0]            word_cnt_next;
    logic [3:0]            dlen_words;

    // One MSB-first step of the CRC; no reflection, no final XOR.
    always_comb begin
        fb            = crc_reg[DATA_WIDTH-1] ^ dat_reg[DATA_WIDTH-1];
        crc_next      = {crc_reg[DATA_WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
        word_cnt_next = word_cnt + 4'd1;
        case (DLEN)
            2'b01:   dlen_words = 4'd4;
            2'b10:   dlen_words = 4'd8;
            default: dlen_words = 4'd1;
        endcase
    end

    // START has priority, so a word offered alongside it is never accepted.
    assign DATA_READY = (state == WAIT_WORD) && !START;
    assign BUSY       = (state == WAIT_WORD) || (state == SHIFT);
    assign SUM_READY  = sum_ready;
    assign WORD_CNT   = word_cnt;

    assign SUM1 = sum_q[0];
    assign SUM2 = sum_q[1];
    assign SUM3 = sum_q[2];
    assign SUM4 = sum_q[3];
    assign SUM5 = sum_q[4];
    assign SUM6 = sum_q[5];
    assign SUM7 = sum_q[6];
    assign SUM8 = sum_q[7];

    always_ff @(posedge HCLK or negedge RESET) begin
        if (!RESET) begin
            state     <= IDLE;
            crc_reg   <= '0;
            dat_reg   <= '0;
            bit_cnt   <= '0;
            len_q     <= '0;
            word_cnt  <= '0;
            sum_ready <= 1'b0;
            for (int i = 0; i < 8; i++) sum_q[i] <= '0;
        end else if (START) begin
            state     <= WAIT_WORD;
            bit_cnt   <= '0;
            len_q     <= dlen_words;
            word_cnt  <= '0;
            sum_ready <= 1'b0;
            for (int i = 0; i < 8; i++) sum_q[i] <= '0;
        end else begin
            case (state)
                WAIT_WORD: begin
                    if (DATA_VALID) begin
                        dat_reg <= DATA_IN;
                        crc_reg <= INIT;
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    crc_reg <= crc_next;
                    dat_reg <= {dat_reg[DATA_WIDTH-2:0], 1'b0};
                    bit_cnt <= bit_cnt + 4'd1;
                    // Sixteenth step: the word is finished, file its CRC.
                    if (bit_cnt == 4'd15) begin
                        sum_q[word_cnt[2:0]] <= crc_next;
                        word_cnt             <= word_cnt_next;
                        if (word_cnt_next == len_q) begin
                            state     <= DONE;
                            sum_ready <= 1'b1;
                        end else begin
                            state <= WAIT_WORD;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
